// File: rtl/conv_window_buffer_pkg.sv
// Shared types and helpers for the sliding-window conv input stage.
package conv_pkg;

    // Frame sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Column counter width for a frame of img_w pixels
    function automatic int col_w(input int img_w);
        return (img_w > 1) ? $clog2(img_w) : 1;
    endfunction

    // Row counter width for a frame of img_h rows
    function automatic int row_w(input int img_h);
        return (img_h > 1) ? $clog2(img_h) : 1;
    endfunction

    // Flattened position of window element (r,c) in a KxK window
    function automatic int idx(input int r, input int c, input int k);
        return r * k + c;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One-row pixel delay: the output is the pixel accepted DEPTH shifts ago.
module conv_line_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 28
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Shift the row one slot on every accepted pixel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (en) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign dout = mem[DEPTH-1];

endmodule

// File: rtl/conv_window_buffer.sv
// Builds KxK sliding windows from a raster pixel stream and hands each
// complete window downstream as one flattened word.
module conv_window_buffer
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int K          = 3,
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28,
    parameter int STRIDE     = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [DATA_WIDTH-1:0]        s_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [K*K*DATA_WIDTH-1:0]    m_data,
    output logic                         busy,
    output logic                         done
);

    localparam int COL_W = col_w(IMG_W);
    localparam int ROW_W = row_w(IMG_H);
    localparam logic PH_MAX = 1'(STRIDE - 1);

    state_t state, next_state;
    logic   done_next;

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             col_ph;
    logic             row_ph;

    logic accept;
    logic last_pixel;
    logic emit;

    logic [DATA_WIDTH-1:0] lb_in   [K-1];
    logic [DATA_WIDTH-1:0] lb_out  [K-1];
    logic [DATA_WIDTH-1:0] taps    [K];
    logic [DATA_WIDTH-1:0] win      [K][K];
    logic [DATA_WIDTH-1:0] win_next [K][K];
    logic [K*K*DATA_WIDTH-1:0] win_flat;

    assign s_ready    = (state == RUN) && (!m_valid || m_ready);
    assign accept     = s_valid && s_ready;
    assign busy       = (state != IDLE);
    assign last_pixel = (row == ROW_W'(IMG_H - 1)) && (col == COL_W'(IMG_W - 1));
    assign emit       = (row >= ROW_W'(K - 1)) && (col >= COL_W'(K - 1)) && !row_ph && !col_ph;

    // Route each line buffer into the next and collect one tap per window row
    always_comb begin
        taps[K-1] = s_data;
        for (int i = 0; i < K - 1; i++) begin
            lb_in[i]        = (i == 0) ? s_data : lb_out[(i == 0) ? 0 : i - 1];
            taps[K-2-i]     = lb_out[i];
        end
    end

    for (genvar g = 0; g < K - 1; g++) begin : g_lb
        conv_line_buffer #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (IMG_W)
        ) u_lb (
            .clk  (clk),
            .rst  (rst),
            .en   (accept),
            .din  (lb_in[g]),
            .dout (lb_out[g])
        );
    end

    // Window after this pixel: shift left, new column enters at the right
    always_comb begin
        win_flat = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
                win_next[r][c] = win[r][c+1];
            end
            win_next[r][K-1] = taps[r];
        end
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                win_flat[idx(r, c, K)*DATA_WIDTH +: DATA_WIDTH] = win_next[r][c];
            end
        end
    end

    // Window column registers advance with each accepted pixel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (accept) begin
            win <= win_next;
        end
    end

    // Raster position and stride phases; a phase only runs once the window fits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col    <= '0;
            row    <= '0;
            col_ph <= 1'b0;
            row_ph <= 1'b0;
        end else if (state == IDLE && start) begin
            col    <= '0;
            row    <= '0;
            col_ph <= 1'b0;
            row_ph <= 1'b0;
        end else if (accept) begin
            if (col == COL_W'(IMG_W - 1)) begin
                col    <= '0;
                col_ph <= 1'b0;
                row    <= last_pixel ? '0 : row + 1'b1;
                if (row >= ROW_W'(K - 1)) begin
                    row_ph <= (row_ph == PH_MAX) ? 1'b0 : row_ph + 1'b1;
                end
            end else begin
                col <= col + 1'b1;
                if (col >= COL_W'(K - 1)) begin
                    col_ph <= (col_ph == PH_MAX) ? 1'b0 : col_ph + 1'b1;
                end
            end
        end
    end

    // Output window register: loads on a completing pixel, clears on drain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
        end else if (accept && emit) begin
            m_valid <= 1'b1;
            m_data  <= win_flat;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

    // Next-state and end-of-frame decision
    always_comb begin
        next_state = state;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (accept && last_pixel) begin
                    next_state = FLUSH;
                end
            end
            FLUSH: begin
                if (!m_valid || m_ready) begin
                    next_state = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register and registered done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= next_state;
            done  <= done_next;
        end
    end

endmodule

// File: tb/tb_conv_window_buffer.sv
// Self-checking bench for conv_window_buffer: a 4x4 stride-1 instance and a
// 5x5 stride-2 instance, driven by directed tables, corner sequences and
// seeded random traffic compared against a window reference model.
module tb_conv_window_buffer;

    localparam int KS = 3;
    localparam int WW = KS * KS * 8;

    typedef struct {
        int              sel;
        int              w;
        int              h;
        int              s;
        int              exp_count;
        int              exp_first_acc;
        logic [WW-1:0]   exp_first;
        logic [WW-1:0]   exp_last;
    } vec_t;

    logic          clk;
    logic          rst;
    logic          start;
    logic          s_valid;
    logic [7:0]    s_data;
    logic          m_ready;
    int            sel;

    logic          a_start, b_start;
    logic          a_s_ready, b_s_ready;
    logic          a_m_valid, b_m_valid;
    logic [WW-1:0] a_m_data, b_m_data;
    logic          a_busy, b_busy;
    logic          a_done, b_done;

    logic          s_ready;
    logic          m_valid;
    logic [WW-1:0] m_data;
    logic          busy;
    logic          done;

    int            n_checks;
    int            n_fail;
    logic [7:0]    pix [25];
    logic [WW-1:0] got_q [$];
    logic [WW-1:0] exp_q [$];
    int            acc_count;
    int            first_acc;
    int            done_count;
    vec_t          vecs [2];

    assign a_start = start && (sel == 0);
    assign b_start = start && (sel == 1);
    assign s_ready = (sel == 1) ? b_s_ready : a_s_ready;
    assign m_valid = (sel == 1) ? b_m_valid : a_m_valid;
    assign m_data  = (sel == 1) ? b_m_data  : a_m_data;
    assign busy    = (sel == 1) ? b_busy    : a_busy;
    assign done    = (sel == 1) ? b_done    : a_done;

    conv_window_buffer #(.DATA_WIDTH(8), .K(KS), .IMG_W(4), .IMG_H(4), .STRIDE(1)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .s_valid(s_valid), .s_ready(a_s_ready),
        .s_data(s_data), .m_valid(a_m_valid), .m_ready(m_ready), .m_data(a_m_data),
        .busy(a_busy), .done(a_done)
    );

    conv_window_buffer #(.DATA_WIDTH(8), .K(KS), .IMG_W(5), .IMG_H(5), .STRIDE(2)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .s_valid(s_valid), .s_ready(b_s_ready),
        .s_data(s_data), .m_valid(b_m_valid), .m_ready(m_ready), .m_data(b_m_data),
        .busy(b_busy), .done(b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pack nine pixels into a window word, element 0 in the low byte
    function automatic logic [WW-1:0] mk(input int e0, input int e1, input int e2,
                                         input int e3, input int e4, input int e5,
                                         input int e6, input int e7, input int e8);
        return {8'(e8), 8'(e7), 8'(e6), 8'(e5), 8'(e4), 8'(e3), 8'(e2), 8'(e1), 8'(e0)};
    endfunction

    task automatic checkOutput(input string name, input logic [WW-1:0] actual,
                               input logic [WW-1:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
        end
    endtask

    // Every valid-padded window anchored on the stride grid, in raster order
    task automatic buildModel(input int w, input int h, input int s);
        logic [WW-1:0] word;
        exp_q.delete();
        for (int r = KS - 1; r < h; r += s) begin
            for (int c = KS - 1; c < w; c += s) begin
                word = '0;
                for (int i = 0; i < KS; i++) begin
                    for (int j = 0; j < KS; j++) begin
                        word[(i*KS + j)*8 +: 8] = pix[(r - (KS - 1) + i)*w + (c - (KS - 1) + j)];
                    end
                end
                exp_q.push_back(word);
            end
        end
    endtask

    task automatic compareWindows(input string tag);
        checkOutput($sformatf("%s_count", tag), WW'(got_q.size()), WW'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checkOutput($sformatf("%s_win%0d", tag, i), got_q[i], exp_q[i]);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_s_ready"}, WW'(s_ready), '0);
        checkOutput({tag, "_m_valid"}, WW'(m_valid), '0);
        checkOutput({tag, "_m_data"},  m_data,       '0);
        checkOutput({tag, "_busy"},    WW'(busy),    '0);
        checkOutput({tag, "_done"},    WW'(done),    '0);
    endtask

    // Runs one frame: pixel feed, optional back-pressure, abort or start pulses,
    // collecting drained windows until done or the cycle budget runs out.
    task automatic applyStimulus(input int sel_i, input int npix, input bit rnd,
                                 input int hold, input logic [WW-1:0] hold_data,
                                 input int abort_at, input int start_run_at,
                                 input bit start_on_done, input bit skip_start);
        int hold_left;
        bit hold_started;
        bit finished;
        bit start_run_done;
        int extra_done;
        hold_left = 0;
        hold_started = 1'b0;
        finished = 1'b0;
        start_run_done = 1'b0;
        extra_done = 0;
        sel = sel_i;
        got_q.delete();
        acc_count = 0;
        first_acc = -1;
        done_count = 0;
        if (skip_start) begin
            checkOutput("restart_busy", WW'(busy), WW'(1));
        end else begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            if (hold > 0 && !hold_started && m_valid) begin
                hold_started = 1'b1;
                hold_left = hold;
            end
            s_valid = (acc_count < npix) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
            s_data  = (acc_count < npix) ? pix[acc_count] : 8'h00;
            m_ready = (hold_left > 0) ? 1'b0 : (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
            if (start_run_at >= 0 && !start_run_done && acc_count >= start_run_at) begin
                start = 1'b1;
                start_run_done = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (hold_left > 0) begin
                checkOutput("bp_m_valid", WW'(m_valid), WW'(1));
                checkOutput("bp_s_ready", WW'(s_ready), '0);
                checkOutput("bp_m_data", m_data, hold_data);
                hold_left--;
            end
            if (m_valid && first_acc < 0) first_acc = acc_count;
            if (m_valid && m_ready) got_q.push_back(m_data);
            if (s_valid && s_ready) acc_count++;
            if (done) begin
                done_count++;
                checkOutput("done_busy_low", WW'(busy), '0);
                finished = 1'b1;
            end
            if (!finished) begin
                @(posedge clk); #1;
                if (abort_at >= 0 && acc_count == abort_at) begin
                    #2;
                    rst = 1'b1;
                    #1;
                    checkIdleOutputs("abort");
                    finished = 1'b1;
                end
            end
        end
        s_valid = 1'b0;
        start = 1'b0;
        if (!finished) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL frame_timeout: actual no done required done within budget");
        end else if (done_count > 0) begin
            if (start_on_done) begin
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end else begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    if (done) extra_done++;
                end
                checkOutput("done_once", WW'(done_count + extra_done), WW'(1));
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        void'($urandom(32'd20240611));
        n_checks = 0;
        n_fail = 0;
        rst = 1'b1;
        start = 1'b0;
        s_valid = 1'b0;
        s_data = 8'h00;
        m_ready = 1'b1;
        sel = 0;

        vecs[0] = '{0, 4, 4, 1, 4, 11, mk(0, 1, 2, 4, 5, 6, 8, 9, 10),
                    mk(5, 6, 7, 9, 10, 11, 13, 14, 15)};
        vecs[1] = '{1, 5, 5, 2, 4, 13, mk(0, 1, 2, 5, 6, 7, 10, 11, 12),
                    mk(12, 13, 14, 17, 18, 19, 22, 23, 24)};

        // Reset state of both instances
        repeat (3) @(posedge clk);
        #1;
        checkIdleOutputs("reset_a");
        sel = 1;
        #1;
        checkIdleOutputs("reset_b");
        sel = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed frames from the table, free-flowing downstream
        for (int v = 0; v < 2; v++) begin
            for (int i = 0; i < vecs[v].w * vecs[v].h; i++) pix[i] = 8'(i);
            applyStimulus(vecs[v].sel, vecs[v].w * vecs[v].h, 1'b0, 0, '0, -1, -1, 1'b0, 1'b0);
            buildModel(vecs[v].w, vecs[v].h, vecs[v].s);
            checkOutput($sformatf("vec%0d_count", v), WW'(got_q.size()), WW'(vecs[v].exp_count));
            checkOutput($sformatf("vec%0d_first", v), (got_q.size() > 0) ? got_q[0] : '0, vecs[v].exp_first);
            checkOutput($sformatf("vec%0d_last", v), (got_q.size() > 0) ? got_q[got_q.size()-1] : '0,
                        vecs[v].exp_last);
            checkOutput($sformatf("vec%0d_first_timing", v), WW'(first_acc), WW'(vecs[v].exp_first_acc));
            compareWindows($sformatf("vec%0d", v));
        end

        // Downstream stall for 5 cycles on the first window
        for (int i = 0; i < 16; i++) pix[i] = 8'(i);
        applyStimulus(0, 16, 1'b0, 5, mk(0, 1, 2, 4, 5, 6, 8, 9, 10), -1, -1, 1'b0, 1'b0);
        buildModel(4, 4, 1);
        checkOutput("bp_total", WW'(got_q.size()), WW'(4));
        compareWindows("bp");

        // Asynchronous reset after pixel 7, then a clean replay
        applyStimulus(0, 16, 1'b0, 0, '0, 8, -1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("abort_no_done", WW'(done), '0);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        applyStimulus(0, 16, 1'b0, 0, '0, -1, -1, 1'b0, 1'b0);
        checkOutput("replay_first", (got_q.size() > 0) ? got_q[0] : '0, mk(0, 1, 2, 4, 5, 6, 8, 9, 10));
        compareWindows("replay");

        // start during RUN is ignored; start in the done cycle chains a frame
        applyStimulus(0, 16, 1'b0, 0, '0, -1, 5, 1'b1, 1'b0);
        compareWindows("srun");
        for (int i = 0; i < 16; i++) pix[i] = 8'(i + 100);
        applyStimulus(0, 16, 1'b0, 0, '0, -1, -1, 1'b0, 1'b1);
        buildModel(4, 4, 1);
        compareWindows("chain");

        // Seeded random valid/ready traffic on both geometries
        for (int it = 0; it < 6; it++) begin
            int s_i;
            int w_i;
            s_i = it % 2;
            w_i = (s_i == 1) ? 5 : 4;
            for (int i = 0; i < w_i * w_i; i++) pix[i] = 8'($urandom);
            applyStimulus(s_i, w_i * w_i, 1'b1, 0, '0, -1, -1, 1'b0, 1'b0);
            buildModel(w_i, w_i, (s_i == 1) ? 2 : 1);
            compareWindows($sformatf("rand%0d", it));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_window_buffer.md
Name: conv_window_buffer

Overview:
- Parametrised successor to the fixed 3x3 conv input register stage.
- Accepts a raster pixel stream and builds KxK sliding windows internally with K-1 line buffers, with stride support.
- Emits each complete window as one flattened word over a valid/ready handshake.
- Sits between the feature-map reader and the conv MAC array; start/done frame the operation.

Parameters:
- DATA_WIDTH, 8: pixel width in bits.
- K, 3: kernel size (2..7).
- IMG_W, 28: frame width in pixels (> K).
- IMG_H, 28: frame height in pixels (>= K).
- STRIDE, 1: window stride (1 or 2), same in both axes.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse that begins a frame; ignored unless IDLE.
- s_valid  in  1  input pixel valid.
- s_ready  out  1  input pixel accepted when s_valid && s_ready.
- s_data  in  DATA_WIDTH  input pixel, raster order.
- m_valid  out  1  window valid.
- m_ready  in  1  downstream ready.
- m_data  out  K*K*DATA_WIDTH  window; element (r,c) at bits [(r*K+c)*DATA_WIDTH +: DATA_WIDTH]; r=0 is the top (oldest) row, c=0 the leftmost column.
- busy  out  1  high in RUN and FLUSH.
- done  out  1  one-cycle pulse at end of frame.

Behaviour:
- Reset: all outputs 0; state IDLE; counters, line buffers and window registers cleared. Reset mid-frame aborts the frame with no done pulse.
- States:
  - IDLE: start -> RUN, clearing the row/col counters.
  - RUN: after the pixel at (IMG_H-1, IMG_W-1) is accepted -> FLUSH.
  - FLUSH: when m_valid==0, or when the final handshake occurs -> IDLE, with done=1 for the following cycle.
- s_ready = (state==RUN) && (!m_valid || m_ready). There is no input acceptance in IDLE or FLUSH.
- Each accepted pixel:
  - shifts into the KxK window column registers;
  - writes into line buffers (row delay IMG_W);
  - advances col, which wraps at IMG_W-1 with row+1.
- Window emission:
  - Valid-padding only; no zero padding.
  - A window is produced when the accepted pixel is at (row, col) with row>=K-1, col>=K-1, (row-(K-1))%STRIDE==0 and (col-(K-1))%STRIDE==0.
  - Implement the stride checks with phase counters, not modulo.
- Latency: m_data/m_valid are registered and appear the cycle after the completing pixel handshake.
- m_valid stays high and m_data stays stable until m_ready. A new window and a drain in the same cycle is legal: the register is overwritten, with no bubble.
- Window count per frame is ((IMG_H-K)/STRIDE+1)*((IMG_W-K)/STRIDE+1).
- Columns straddling a row wrap must never form a window. The col>=K-1 rule guarantees this.
- start while busy is ignored. s_valid while not ready is held by the upstream and not consumed.
- A back-to-back frame is allowed: start is accepted in the cycle done is high (state is already IDLE).

Decomposition:
- Package conv_pkg holds:
  - state encoding (IDLE/RUN/FLUSH);
  - COL_W=$clog2(IMG_W) and ROW_W=$clog2(IMG_H) width helpers;
  - a window index function idx(r,c)=r*K+c.
- One sub-module, conv_line_buffer:
  - one-row delay of depth IMG_W, width DATA_WIDTH, with shift enable;
  - instantiated K-1 times in a chain;
  - inferable as register shift or RAM with a circular pointer.

Test Plan:
- K=3, IMG_W=IMG_H=4, STRIDE=1, pixels 0..15, m_ready=1:
  - expect 4 windows;
  - the first appears the cycle after pixel 10 is accepted, {0,1,2,4,5,6,8,9,10};
  - the last is {5,6,7,9,10,11,13,14,15};
  - done pulses once after drain.
- K=3, IMG_W=IMG_H=5, STRIDE=2, pixels 0..24:
  - exactly 4 windows, anchored at (2,2), (2,4), (4,2), (4,4);
  - the first is {0,1,2,5,6,7,10,11,12};
  - the last is {12,13,14,17,18,19,22,23,24}.
- 4x4 case with m_ready held low for 5 cycles after the first window:
  - m_data holds {0,1,2,4,5,6,8,9,10};
  - s_ready is 0 while m_valid is high and m_ready is low;
  - no window is lost or duplicated, and the total is still 4.
- rst asserted asynchronously mid-frame after pixel 7:
  - all outputs 0 immediately, with no done;
  - a new start replays the full frame with the correct first window.
- start pulsed during RUN, then again in the done cycle:
  - the first pulse is ignored;
  - the second starts the next frame.
- s_valid toggled randomly (seeded) with random m_ready: the window sequence must match the golden model.
